// File: rtl/cpu_clken_gen.sv
// cpu_clken_gen: CPU bus clock and phi1/phi2 enable generator with runtime even divider, pause/step and period counter
module cpu_clken_gen #(
    parameter int DIV_W     = 4,
    parameter int DIV_RESET = 4,
    parameter int PC_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] div,
    output logic             div_ack,
    input  logic             pause_req,
    input  logic             step,
    output logic             clk_out,
    output logic             phi1,
    output logic             phi2,
    output logic             paused,
    output logic [PC_W-1:0]  period_cnt
);
    typedef enum logic [1:0] {RUN, PAUSED, STEP} state_t;
    state_t           state;
    logic [DIV_W-1:0] cnt, n_cur, neff, half, last;
    logic             active, period_end, sample, change;
    // odd requests round down to even, anything below 2 becomes 2
    always_comb begin
        neff       = div[DIV_W-1:1] == '0 ? DIV_W'(2) : {div[DIV_W-1:1], 1'b0};
        half       = n_cur >> 1;
        last       = n_cur - DIV_W'(1);
        active     = state == RUN || state == STEP;
        period_end = active && cnt == last;
        sample     = period_end || state == PAUSED;
        change     = sample && neff != n_cur;
        clk_out    = active && cnt >= half;
        phi1       = active && cnt == '0;
        phi2       = active && cnt == half;
        paused     = state == PAUSED;
    end
    // state, phase counter, ratio and period count; ratio only moves on period boundaries or while paused
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= PAUSED;
            cnt        <= '0;
            n_cur      <= DIV_W'(DIV_RESET);
            period_cnt <= '0;
            div_ack    <= 1'b0;
        end else begin
            div_ack <= change;
            if (change) n_cur <= neff;
            if (phi1) period_cnt <= period_cnt + PC_W'(1);
            if (state == PAUSED) begin
                cnt <= '0;
                if (!pause_req) state <= RUN;
                else if (step) state <= STEP;
            end else if (period_end) begin
                cnt   <= '0;
                state <= pause_req ? PAUSED : RUN;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cpu_clken_gen.sv
// tb_cpu_clken_gen: table-driven and directed checks of cpu_clken_gen
module tb_cpu_clken_gen;
    logic        clk = 1'b0;
    logic        rstn, pause_req, step, div_ack, clk_out, phi1, phi2, paused;
    logic [3:0]  div;
    logic [31:0] period_cnt;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        rstn, pr, st;
        logic [3:0]  dv;
        logic        e_clk, e_p1, e_p2, e_pa, e_ack;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vec[$];

    cpu_clken_gen dut (
        .clk(clk), .rstn(rstn), .div(div), .div_ack(div_ack),
        .pause_req(pause_req), .step(step), .clk_out(clk_out),
        .phi1(phi1), .phi2(phi2), .paused(paused), .period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic pr, st, input logic [3:0] dv,
                                input logic ec, e1, e2, ep, ea, input logic [31:0] epc);
        vec_t v;
        v.rstn = 1'b1; v.pr = pr; v.st = st; v.dv = dv;
        v.e_clk = ec; v.e_p1 = e1; v.e_p2 = e2; v.e_pa = ep; v.e_ack = ea; v.e_pc = epc;
        vec.push_back(v);
    endfunction

    task automatic ratio(input logic [3:0] d, input int n);
        int t = 0, per = 0, hi = 0, p2 = -1;
        div = d;
        @(negedge clk);
        while (!phi1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("ratio%0d_sync", d), 32'(phi1), 32'd1);
        do begin
            if (clk_out) hi++;
            if (phi2) p2 = per;
            per++;
            @(negedge clk);
        end while (!phi1 && per < 40);
        chk($sformatf("ratio%0d_period", d), 32'(per), 32'(n));
        chk($sformatf("ratio%0d_high", d), 32'(hi), 32'(n / 2));
        chk($sformatf("ratio%0d_phi2", d), 32'(p2), 32'(n / 2));
    endtask

    initial begin
        int t;
        //   pr st div clk p1 p2 pa ack pc
        add(0, 0, 4, 0, 0, 0, 1, 0, 0);
        add(0, 0, 4, 0, 1, 0, 0, 0, 0);
        add(0, 0, 4, 0, 0, 0, 0, 0, 1);
        add(0, 0, 4, 1, 0, 1, 0, 0, 1);
        add(0, 0, 4, 1, 0, 0, 0, 0, 1);
        add(0, 0, 4, 0, 1, 0, 0, 0, 1);
        add(0, 0, 6, 0, 0, 0, 0, 0, 2);
        add(0, 0, 6, 1, 0, 1, 0, 0, 2);
        add(0, 0, 6, 1, 0, 0, 0, 0, 2);
        add(0, 0, 6, 0, 1, 0, 0, 1, 2);
        add(0, 0, 6, 0, 0, 0, 0, 0, 3);
        add(0, 0, 6, 0, 0, 0, 0, 0, 3);
        add(0, 0, 6, 1, 0, 1, 0, 0, 3);
        add(0, 0, 6, 1, 0, 0, 0, 0, 3);
        add(0, 0, 6, 1, 0, 0, 0, 0, 3);
        add(0, 0, 6, 0, 1, 0, 0, 0, 3);
        add(0, 0, 4, 0, 0, 0, 0, 0, 4);
        add(0, 0, 4, 0, 0, 0, 0, 0, 4);
        add(0, 0, 4, 1, 0, 1, 0, 0, 4);
        add(0, 0, 4, 1, 0, 0, 0, 0, 4);
        add(0, 0, 4, 1, 0, 0, 0, 0, 4);
        add(0, 0, 4, 0, 1, 0, 0, 1, 4);
        add(1, 0, 4, 0, 0, 0, 0, 0, 5);
        add(1, 0, 4, 1, 0, 1, 0, 0, 5);
        add(1, 0, 4, 1, 0, 0, 0, 0, 5);
        add(1, 0, 4, 0, 0, 0, 1, 0, 5);
        add(1, 0, 4, 0, 0, 0, 1, 0, 5);
        add(1, 1, 4, 0, 0, 0, 1, 0, 5);
        add(1, 0, 4, 0, 1, 0, 0, 0, 5);
        add(1, 0, 4, 0, 0, 0, 0, 0, 6);
        add(1, 0, 4, 1, 0, 1, 0, 0, 6);
        add(1, 0, 4, 1, 0, 0, 0, 0, 6);
        for (int i = 0; i < 5; i++) add(1, 0, 4, 0, 0, 0, 1, 0, 6);
        add(1, 1, 4, 0, 0, 0, 1, 0, 6);
        add(1, 0, 4, 0, 1, 0, 0, 0, 6);
        add(1, 1, 4, 0, 0, 0, 0, 0, 7);
        add(1, 0, 4, 1, 0, 1, 0, 0, 7);
        add(1, 0, 4, 1, 0, 0, 0, 0, 7);
        add(0, 0, 4, 0, 0, 0, 1, 0, 7);
        add(0, 0, 4, 0, 1, 0, 0, 0, 7);
        add(0, 0, 4, 0, 0, 0, 0, 0, 8);

        rstn = 1'b0; pause_req = 1'b0; step = 1'b0; div = 4'd4;
        @(negedge clk);
        @(negedge clk);
        foreach (vec[i]) begin
            rstn = vec[i].rstn; pause_req = vec[i].pr; step = vec[i].st; div = vec[i].dv;
            chk($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'(vec[i].e_clk));
            chk($sformatf("vec%0d_phi1", i), 32'(phi1), 32'(vec[i].e_p1));
            chk($sformatf("vec%0d_phi2", i), 32'(phi2), 32'(vec[i].e_p2));
            chk($sformatf("vec%0d_paused", i), 32'(paused), 32'(vec[i].e_pa));
            chk($sformatf("vec%0d_div_ack", i), 32'(div_ack), 32'(vec[i].e_ack));
            chk($sformatf("vec%0d_period_cnt", i), period_cnt, vec[i].e_pc);
            @(negedge clk);
        end
        pause_req = 1'b0; step = 1'b0;

        ratio(4'd0, 2);
        ratio(4'd1, 2);
        ratio(4'd7, 6);
        ratio(4'd2, 2);
        ratio(4'd4, 4);

        t = 0;
        while (period_cnt != 32'h1234 && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_pc_1234", period_cnt, 32'h1234);
        @(negedge clk);
        chk("pre_reset_phi2", 32'(phi2), 32'd1);
        rstn = 1'b0; div = 4'd6;
        @(negedge clk);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_phi1", 32'(phi1), 32'd0);
        chk("rst_phi2", 32'(phi2), 32'd0);
        chk("rst_paused", 32'(paused), 32'd1);
        chk("rst_period_cnt", period_cnt, 32'd0);
        chk("rst_div_ack", 32'(div_ack), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_phi1", 32'(phi1), 32'd1);
        chk("post_rst_ack", 32'(div_ack), 32'd1);
        chk("post_rst_paused", 32'(paused), 32'd0);
        ratio(4'd6, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
